oblivious_transfer_receiver: RTL

- Receiver (chooser) end of 1-out-of-2 RSA oblivious transfer over a byte stream. Talks to the OT sender through the same rx/tx valid/ready byte interface.
- Receives the public key (N, e) and random values x0, x1. Blinds the chosen x_b with k^e and sends v back.
- Receives the masked messages m0', m1' and unmasks only m_b. Sits between the UART byte bridge and the host-side control logic.

---
 rtl/ot_pkg.sv | 32 +++
 rtl/oblivious_transfer_receiver_if.sv | 14 +
 rtl/oblivious_transfer_receiver_mod_exp.sv | 115 +++++++++++
 rtl/oblivious_transfer_receiver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ot_pkg.sv
// Shared definitions for the OT receiver: FSM encodings, default operand width
// and byte-counter sizing helper.
package ot_pkg;

  localparam int unsigned OT_W = 32;

  // Receiver protocol states, in stream order
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_RX_N  = 4'd1;
  localparam logic [3:0] ST_RX_E  = 4'd2;
  localparam logic [3:0] ST_RX_X0 = 4'd3;
  localparam logic [3:0] ST_RX_X1 = 4'd4;
  localparam logic [3:0] ST_EXP   = 4'd5;
  localparam logic [3:0] ST_ADD   = 4'd6;
  localparam logic [3:0] ST_TX_V  = 4'd7;
  localparam logic [3:0] ST_RX_M0 = 4'd8;
  localparam logic [3:0] ST_RX_M1 = 4'd9;
  localparam logic [3:0] ST_SUB   = 4'd10;
  localparam logic [3:0] ST_DONE  = 4'd11;
  localparam logic [3:0] ST_ERR   = 4'd12;

  // Modular exponentiator states
  localparam logic [1:0] ME_IDLE = 2'd0;
  localparam logic [1:0] ME_SQ   = 2'd1;
  localparam logic [1:0] ME_MUL  = 2'd2;

  // Counter width able to index 0..n-1, never narrower than one bit
  function automatic int unsigned ot_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oblivious_transfer_receiver_if.sv
// Byte-stream link between the OT receiver and the UART bridge (rx inbound, tx outbound).
interface oblivious_transfer_receiver_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport slave  (input  rx_valid, rx_data, tx_ready,
                  output rx_ready, tx_valid, tx_data);
  modport master (output rx_valid, rx_data, tx_ready,
                  input  rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/oblivious_transfer_receiver_mod_exp.sv
// base^exp mod mod by MSB-first square-and-multiply; each modular multiply is a
// W-cycle shift-add with conditional subtract. Requires base < mod and mod >= 2.
module mod_exp
  import ot_pkg::*;
#(
  parameter int unsigned W = OT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] base_i,
  input  logic [W-1:0] exp_i,
  input  logic [W-1:0] mod_i,
  output logic         done_o,
  output logic [W-1:0] result_o
);

  localparam int unsigned SW = ot_cnt_w(W);

  logic [1:0]    st_q, st_d;
  logic [W-1:0]  base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [W-1:0]  res_q, res_d, acc_q, acc_d;
  logic [SW-1:0] bit_q, bit_d, step_q, step_d;
  logic          done_q, done_d;
  logic [W-1:0]  mul_b_c, acc_next_c;

  // One shift-add step: acc' = (2*acc + abit*b) mod m, with acc, b < m
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc, input logic abit,
                                           input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (abit) begin
      t = t + {1'b0, b};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[W-1:0];
  endfunction

  assign mul_b_c    = (st_q == ME_SQ) ? res_q : base_q;
  assign acc_next_c = mm_step(acc_q, res_q[step_q], mul_b_c, mod_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ME_IDLE;
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      res_q  <= '0;
      acc_q  <= '0;
      bit_q  <= '0;
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      base_q <= base_d;
      exp_q  <= exp_d;
      mod_q  <= mod_d;
      res_q  <= res_d;
      acc_q  <= acc_d;
      bit_q  <= bit_d;
      step_q <= step_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    base_d = base_q;
    exp_d  = exp_q;
    mod_d  = mod_q;
    res_d  = res_q;
    acc_d  = acc_q;
    bit_d  = bit_q;
    step_d = step_q;
    done_d = 1'b0;
    case (st_q)
      ME_IDLE: begin
        if (start_i) begin
          base_d = base_i;
          exp_d  = exp_i;
          mod_d  = mod_i;
          res_d  = W'(1);
          acc_d  = '0;
          bit_d  = SW'(W - 1);
          step_d = SW'(W - 1);
          st_d   = ME_SQ;
        end
      end
      ME_SQ, ME_MUL: begin
        acc_d  = acc_next_c;
        step_d = SW'(step_q - 1'b1);
        if (step_q == '0) begin
          res_d  = acc_next_c;
          acc_d  = '0;
          step_d = SW'(W - 1);
          if (st_q == ME_SQ && exp_q[bit_q]) begin
            st_d = ME_MUL;
          end else if (bit_q == '0) begin
            st_d   = ME_IDLE;
            done_d = 1'b1;
          end else begin
            bit_d = SW'(bit_q - 1'b1);
            st_d  = ME_SQ;
          end
        end
      end
      default: st_d = ME_IDLE;
    endcase
  end

  assign done_o   = done_q;
  assign result_o = res_q;

endmodule

// File: rtl/oblivious_transfer_receiver.sv
// Chooser side of 1-out-of-2 RSA oblivious transfer: receives (N, e, x0, x1),
// returns v = x_b + k^e mod N, then unmasks m_b from (m0', m1').
module oblivious_transfer_receiver
  import ot_pkg::*;
#(
  parameter int unsigned W = OT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          choice,
  input  logic [W-1:0]                  rand_k,
  oblivious_transfer_receiver_if.slave  bus,
  output logic [W-1:0]                  message,
  output logic                          done,
  output logic                          busy,
  output logic                          error
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned CW = ot_cnt_w(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [3:0]    state_q, state_d;
  logic          b_q, b_d;
  logic [W-1:0]  k_q, k_d, n_q, n_d, e_q, e_d, xb_q, xb_d, mb_q, mb_d;
  logic [W-1:0]  sh_q, sh_d, txsh_q, txsh_d, message_q, message_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          me_start_q, me_start_d;
  logic          done_q, done_d, busy_q, busy_d, error_q, error_d;

  logic          rx_ready_c, rx_fire_c, word_done_c, me_done_c;
  logic [W-1:0]  word_c, me_res_c, txsh_next_c, add_v_c, sub_m_c;
  logic [W:0]    add_t_c;

  mod_exp #(.W(W)) u_mod_exp (
    .clk      (clk),
    .rst      (reset),
    .start_i  (me_start_q),
    .base_i   (k_q),
    .exp_i    (e_q),
    .mod_i    (n_q),
    .done_o   (me_done_c),
    .result_o (me_res_c)
  );

  assign rx_ready_c  = state_q inside {ST_RX_N, ST_RX_E, ST_RX_X0, ST_RX_X1, ST_RX_M0, ST_RX_M1};
  assign rx_fire_c   = bus.rx_valid && rx_ready_c;
  assign word_done_c = rx_fire_c && (cnt_q == LAST);
  assign word_c      = W'({sh_q, bus.rx_data});
  assign txsh_next_c = W'({txsh_q, 8'h00});

  // Blind: v = (x_b + k^e) mod N, both operands already below N
  assign add_t_c = {1'b0, xb_q} + {1'b0, me_res_c};
  assign add_v_c = (add_t_c >= {1'b0, n_q}) ? W'(add_t_c - {1'b0, n_q}) : W'(add_t_c);
  // Unmask: m = (m'_b - k) mod N
  assign sub_m_c = (mb_q >= k_q) ? W'(mb_q - k_q)
                                 : W'({1'b0, mb_q} + {1'b0, n_q} - {1'b0, k_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      b_q        <= 1'b0;
      k_q        <= '0;
      n_q        <= '0;
      e_q        <= '0;
      xb_q       <= '0;
      mb_q       <= '0;
      sh_q       <= '0;
      txsh_q     <= '0;
      message_q  <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      me_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      k_q        <= k_d;
      n_q        <= n_d;
      e_q        <= e_d;
      xb_q       <= xb_d;
      mb_q       <= mb_d;
      sh_q       <= sh_d;
      txsh_q     <= txsh_d;
      message_q  <= message_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      me_start_q <= me_start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    k_d        = k_q;
    n_d        = n_q;
    e_d        = e_q;
    xb_d       = xb_q;
    mb_d       = mb_q;
    sh_d       = sh_q;
    txsh_d     = txsh_q;
    message_d  = message_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    me_start_d = 1'b0;
    done_d     = done_q;
    error_d    = error_q;

    if (rx_fire_c) begin
      sh_d  = word_c;
      cnt_d = word_done_c ? '0 : CW'(cnt_q + 1'b1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          b_d     = choice;
          k_d     = rand_k;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RX_N;
        end
      end
      ST_RX_N: begin
        if (word_done_c) begin
          n_d = word_c;
          if (word_c < W'(2)) begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end else begin
            state_d = ST_RX_E;
          end
        end
      end
      ST_RX_E: begin
        if (word_done_c) begin
          e_d     = word_c;
          state_d = ST_RX_X0;
        end
      end
      ST_RX_X0: begin
        if (word_done_c) begin
          if (!b_q) xb_d = word_c;
          state_d = ST_RX_X1;
        end
      end
      ST_RX_X1: begin
        if (word_done_c) begin
          if (b_q) xb_d = word_c;
          me_start_d = 1'b1;
          state_d    = ST_EXP;
        end
      end
      ST_EXP: begin
        if (me_done_c) state_d = ST_ADD;
      end
      ST_ADD: begin
        txsh_d     = add_v_c;
        tx_data_d  = add_v_c[W-1 -: 8];
        tx_valid_d = 1'b1;
        cnt_d      = '0;
        state_d    = ST_TX_V;
      end
      ST_TX_V: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (cnt_q == LAST) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            cnt_d      = '0;
            state_d    = ST_RX_M0;
          end else begin
            txsh_d    = txsh_next_c;
            tx_data_d = txsh_next_c[W-1 -: 8];
            cnt_d     = CW'(cnt_q + 1'b1);
          end
        end
      end
      ST_RX_M0: begin
        if (word_done_c) begin
          if (!b_q) mb_d = word_c;
          state_d = ST_RX_M1;
        end
      end
      ST_RX_M1: begin
        if (word_done_c) begin
          if (b_q) mb_d = word_c;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        message_d = sub_m_c;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  assign bus.rx_ready = rx_ready_c;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign message      = message_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule
